// File: rtl/endec_frame_encoder.sv
// Frame-based convolutional encoder with runtime K, rate 1/n and generator polynomials.
// Valid/ready on both sides, optional zero-tail termination, o_sym_last marks the frame end.
module endec_frame_encoder #(
  parameter int unsigned MAX_K     = 9,
  parameter int unsigned MAX_RATE  = 3,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [3:0]                i_cfg_k,
  input  logic [1:0]                i_cfg_n,
  input  logic [MAX_RATE*MAX_K-1:0] i_gen_poly,
  input  logic                      i_term_mode,
  input  logic                      i_bit,
  input  logic                      i_bit_valid,
  output logic                      o_bit_ready,
  output logic [MAX_RATE-1:0]       o_sym,
  output logic                      o_sym_valid,
  input  logic                      i_sym_ready,
  output logic                      o_sym_last,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRun, StTail, StDrain} state_e;

  state_e                      state_q;
  logic [3:0]                  k_q;
  logic [1:0]                  n_q;
  logic [MAX_RATE*MAX_K-1:0]   poly_q;
  logic                        mode_q;
  logic [MAX_K-2:0]            sr_q;
  logic [CntW-1:0]             data_cnt_q;
  logic [3:0]                  tail_cnt_q;
  logic [MAX_RATE-1:0]         sym_q;
  logic                        sym_valid_q;
  logic                        sym_last_q;
  logic                        busy_q;
  logic                        err_q;

  logic                        slot_free;
  logic                        xfer;
  logic                        handshake;
  logic                        cfg_ok;
  logic                        enc_bit;
  logic [MAX_K-1:0]            window;
  logic [MAX_K-1:0]            k_mask;
  logic [MAX_RATE-1:0]         enc_sym;

  assign slot_free   = !sym_valid_q || i_sym_ready;
  assign o_bit_ready = (state_q == StRun) && slot_free;
  assign xfer        = i_bit_valid && o_bit_ready;
  assign handshake   = sym_valid_q && i_sym_ready;
  assign cfg_ok      = (i_cfg_k >= 4'd3) && (32'(i_cfg_k) <= MAX_K) &&
                       (i_cfg_n >= 2'd2) && (32'(i_cfg_n) <= MAX_RATE);

  // Tail slots feed zeros through the same encoder path.
  assign enc_bit = (state_q == StRun) ? i_bit : 1'b0;
  assign window  = {sr_q, enc_bit};
  // Shift past MAX_K yields 0, so minus one gives all ones when K == MAX_K.
  assign k_mask  = (MAX_K'(1) << k_q) - MAX_K'(1);

  always_comb begin
    enc_sym = '0;
    for (int j = 0; j < int'(MAX_RATE); j++) begin
      if (j < int'(n_q)) begin
        enc_sym[j] = ^(window & poly_q[j*MAX_K +: MAX_K] & k_mask);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      n_q         <= '0;
      poly_q      <= '0;
      mode_q      <= 1'b0;
      sr_q        <= '0;
      data_cnt_q  <= '0;
      tail_cnt_q  <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            if (cfg_ok) begin
              k_q        <= i_cfg_k;
              n_q        <= i_cfg_n;
              poly_q     <= i_gen_poly;
              mode_q     <= i_term_mode;
              sr_q       <= '0;
              data_cnt_q <= '0;
              tail_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= StRun;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (xfer) begin
            sym_q       <= enc_sym;
            sym_valid_q <= 1'b1;
            sr_q        <= {sr_q[MAX_K-3:0], enc_bit};
            data_cnt_q  <= data_cnt_q + CntW'(1);
            if (data_cnt_q == CntW'(FRAME_LEN - 1)) begin
              sym_last_q <= !mode_q;
              state_q    <= mode_q ? StTail : StDrain;
            end else begin
              sym_last_q <= 1'b0;
            end
          end else if (handshake) begin
            sym_valid_q <= 1'b0;
          end
        end
        StTail: begin
          if (slot_free) begin
            sym_q       <= enc_sym;
            sym_valid_q <= 1'b1;
            sr_q        <= {sr_q[MAX_K-3:0], enc_bit};
            tail_cnt_q  <= tail_cnt_q + 4'd1;
            if (tail_cnt_q == k_q - 4'd2) begin
              sym_last_q <= 1'b1;
              state_q    <= StDrain;
            end else begin
              sym_last_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          // Only the last symbol can be pending here.
          if (handshake) begin
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_sym       = sym_q;
  assign o_sym_valid = sym_valid_q;
  assign o_sym_last  = sym_last_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_endec_frame_encoder.sv
// Scoreboard bench for endec_frame_encoder: expected symbols are queued per frame
// and popped on each output handshake.
module tb_endec_frame_encoder;

  localparam int unsigned MAX_K    = 9;
  localparam int unsigned MAX_RATE = 3;
  localparam int unsigned FL       = 4;

  logic                      sys_clk = 1'b0;
  logic                      rst;
  logic                      i_start;
  logic [3:0]                i_cfg_k;
  logic [1:0]                i_cfg_n;
  logic [MAX_RATE*MAX_K-1:0] i_gen_poly;
  logic                      i_term_mode;
  logic                      i_bit;
  logic                      i_bit_valid;
  logic                      o_bit_ready;
  logic [MAX_RATE-1:0]       o_sym;
  logic                      o_sym_valid;
  logic                      i_sym_ready;
  logic                      o_sym_last;
  logic                      o_busy;
  logic                      o_err;

  typedef struct packed {
    logic [MAX_RATE-1:0] sym;
    logic                last;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 sys_clk = ~sys_clk;

  endec_frame_encoder #(
    .MAX_K    (MAX_K),
    .MAX_RATE (MAX_RATE),
    .FRAME_LEN(FL)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_cfg_k    (i_cfg_k),
    .i_cfg_n    (i_cfg_n),
    .i_gen_poly (i_gen_poly),
    .i_term_mode(i_term_mode),
    .i_bit      (i_bit),
    .i_bit_valid(i_bit_valid),
    .o_bit_ready(o_bit_ready),
    .o_sym      (o_sym),
    .o_sym_valid(o_sym_valid),
    .i_sym_ready(i_sym_ready),
    .o_sym_last (o_sym_last),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  // Reference: direct tap sum over the input history, tail bits are zeros.
  task automatic push_model(input int k, input int n, input logic [MAX_RATE*MAX_K-1:0] polys,
                            input logic mode, input logic [FL-1:0] bits);
    int   total;
    exp_t e;
    total = mode ? int'(FL) + k - 1 : int'(FL);
    for (int t = 0; t < total; t++) begin
      e = '0;
      for (int j = 0; j < n; j++) begin
        for (int i = 0; i < k; i++) begin
          if (t - i >= 0 && t - i < int'(FL)) begin
            e.sym[j] = e.sym[j] ^ (polys[j*MAX_K + i] & bits[t - i]);
          end
        end
      end
      e.last = (t == total - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(input int k, input int n, input logic [MAX_RATE*MAX_K-1:0] polys,
                           input logic mode, input logic [FL-1:0] bits, input logic stall,
                           input logic busy_start, input string name);
    int                  idx = 0;
    int                  cyc = 0;
    logic                done = 1'b0;
    logic                seen = 1'b0;
    logic                have_held = 1'b0;
    logic [MAX_RATE-1:0] held_sym = '0;
    logic                held_last = 1'b0;
    exp_t                e;
    @(posedge sys_clk); #1;
    i_cfg_k = 4'(k); i_cfg_n = 2'(n); i_gen_poly = polys; i_term_mode = mode;
    i_start = 1'b1;
    while (!done && cyc < 60) begin
      @(posedge sys_clk); #1;
      i_start     = busy_start && (cyc == 2);
      i_cfg_k     = (busy_start && cyc == 2) ? 4'd2 : 4'(k);
      i_bit_valid = (idx < int'(FL));
      i_bit       = (idx < int'(FL)) ? bits[idx] : 1'b0;
      i_sym_ready = !(stall && cyc >= 3 && cyc < 6);
      @(negedge sys_clk);
      if (cyc == 0) begin
        n_total++;
        if (o_busy !== 1'b1) $display("FAIL %s busy: got %b want 1", name, o_busy);
        else n_pass++;
      end
      if (busy_start && cyc == 3) begin
        n_total++;
        if (o_err !== 1'b0) $display("FAIL %s start_while_busy err: got %b want 0", name, o_err);
        else n_pass++;
      end
      if (!i_sym_ready && o_sym_valid) begin
        n_total++;
        if (o_bit_ready !== 1'b0) $display("FAIL %s stall bit_ready: got %b want 0", name, o_bit_ready);
        else n_pass++;
        if (have_held) begin
          n_total++;
          if ({o_sym, o_sym_last} !== {held_sym, held_last})
            $display("FAIL %s stall hold: got %b/%b want %b/%b", name, o_sym, o_sym_last,
                     held_sym, held_last);
          else n_pass++;
        end
        held_sym = o_sym; held_last = o_sym_last; have_held = 1'b1;
      end else begin
        have_held = 1'b0;
      end
      if (!stall && seen) begin
        n_total++;
        if (o_sym_valid !== 1'b1) $display("FAIL %s back_to_back valid: got %b want 1", name, o_sym_valid);
        else n_pass++;
      end
      if (o_sym_valid) seen = 1'b1;
      if (o_bit_ready && i_bit_valid) idx++;
      if (o_sym_valid && i_sym_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra symbol: got %b want none", name, o_sym);
          done = 1'b1;
        end else begin
          e = exp_q.pop_front();
          if ({o_sym, o_sym_last} !== {e.sym, e.last})
            $display("FAIL %s sym: got %b last %b want %b last %b", name, o_sym, o_sym_last,
                     e.sym, e.last);
          else n_pass++;
          if (e.last) done = 1'b1;
        end
      end
      cyc++;
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s timeout: got %0d pending want 0", name, exp_q.size());
    end
    @(posedge sys_clk); #1;
    i_bit_valid = 1'b0; i_sym_ready = 1'b1;
    @(negedge sys_clk);
    n_total++;
    if ({o_busy, o_sym_valid, exp_q.size() == 0} !== 3'b001)
      $display("FAIL %s end state: got busy %b valid %b left %0d want 0 0 0", name, o_busy,
               o_sym_valid, exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_cfg_k = '0; i_cfg_n = '0; i_gen_poly = '0;
    i_term_mode = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0; i_sym_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    n_total++;
    if ({o_sym, o_sym_valid, o_sym_last, o_busy, o_err, o_bit_ready} !== '0)
      $display("FAIL reset outputs: got %b want 0",
               {o_sym, o_sym_valid, o_sym_last, o_busy, o_err, o_bit_ready});
    else n_pass++;
    @(posedge sys_clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_tail();
    exp_q.push_back('{sym: 3'b011, last: 1'b0});
    exp_q.push_back('{sym: 3'b001, last: 1'b0});
    exp_q.push_back('{sym: 3'b000, last: 1'b0});
    exp_q.push_back('{sym: 3'b010, last: 1'b0});
    exp_q.push_back('{sym: 3'b010, last: 1'b0});
    exp_q.push_back('{sym: 3'b011, last: 1'b1});
    run_frame(3, 2, {9'd0, 9'b101, 9'b111}, 1'b1, 4'b1101, 1'b0, 1'b0, "tail");
  endtask

  task automatic test_truncated();
    exp_q.push_back('{sym: 3'b011, last: 1'b0});
    exp_q.push_back('{sym: 3'b001, last: 1'b0});
    exp_q.push_back('{sym: 3'b000, last: 1'b0});
    exp_q.push_back('{sym: 3'b010, last: 1'b1});
    run_frame(3, 2, {9'd0, 9'b101, 9'b111}, 1'b0, 4'b1101, 1'b0, 1'b0, "truncated");
  endtask

  task automatic test_backpressure();
    logic [MAX_RATE*MAX_K-1:0] polys;
    polys = {9'b1011, 9'b1101, 9'b1111};
    push_model(4, 3, polys, 1'b1, 4'b1011);
    run_frame(4, 3, polys, 1'b1, 4'b1011, 1'b1, 1'b1, "backpressure");
  endtask

  task automatic test_full_k();
    logic [MAX_RATE*MAX_K-1:0] polys;
    polys = {9'd0, 9'b110110101, 9'b101110111};
    push_model(9, 2, polys, 1'b1, 4'b0111);
    run_frame(9, 2, polys, 1'b1, 4'b0111, 1'b0, 1'b0, "full_k");
  endtask

  task automatic test_illegal_cfg();
    logic [3:0] ks [3] = '{4'd2, 4'd3, 4'd10};
    logic [1:0] ns [3] = '{2'd2, 2'd0, 2'd3};
    for (int c = 0; c < 3; c++) begin
      @(posedge sys_clk); #1;
      i_cfg_k = ks[c]; i_cfg_n = ns[c]; i_start = 1'b1;
      @(posedge sys_clk); #1;
      i_start = 1'b0;
      @(negedge sys_clk);
      n_total++;
      if ({o_err, o_busy} !== 2'b10) $display("FAIL illegal_cfg %0d pulse: got err %b busy %b want 1 0",
                                             c, o_err, o_busy);
      else n_pass++;
      @(negedge sys_clk);
      n_total++;
      if ({o_err, o_busy} !== 2'b00) $display("FAIL illegal_cfg %0d clear: got err %b busy %b want 0 0",
                                             c, o_err, o_busy);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    @(posedge sys_clk); #1;
    i_cfg_k = 4'd3; i_cfg_n = 2'd2; i_gen_poly = {9'd0, 9'b101, 9'b111}; i_term_mode = 1'b1;
    i_start = 1'b1;
    @(posedge sys_clk); #1;
    i_start = 1'b0; i_bit_valid = 1'b1; i_bit = 1'b1; i_sym_ready = 1'b0;
    @(posedge sys_clk); #1;
    i_bit = 1'b0; i_sym_ready = 1'b1;
    @(posedge sys_clk); #1;
    i_bit_valid = 1'b0; rst = 1'b1;
    @(negedge sys_clk);
    n_total++;
    if (o_sym_valid !== 1'b1) $display("FAIL mid_reset pre: got valid %b want 1", o_sym_valid);
    else n_pass++;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    n_total++;
    if ({o_sym, o_sym_valid, o_sym_last, o_busy, o_err, o_bit_ready} !== '0)
      $display("FAIL mid_reset outputs: got %b want 0",
               {o_sym, o_sym_valid, o_sym_last, o_busy, o_err, o_bit_ready});
    else n_pass++;
    push_model(3, 2, {9'd0, 9'b101, 9'b111}, 1'b1, 4'b1101);
    run_frame(3, 2, {9'd0, 9'b101, 9'b111}, 1'b1, 4'b1101, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_tail();
    test_truncated();
    test_backpressure();
    test_full_k();
    test_illegal_cfg();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
